// File: rtl/aes_loader_pkg.sv
// aes_loader_pkg: shared constants and types for the AES byte-stream loader.
//   BLOCK_BYTES / MAX_KEY_BYTES : byte counts of the plaintext block and the largest key
//   KEY_CNT_W / DATA_CNT_W      : widths of the key and data byte counters
//   loader_state_t              : loader FSM state
package aes_loader_pkg;

    localparam int BLOCK_BYTES   = 16;
    localparam int MAX_KEY_BYTES = 32;
    localparam int KEY_CNT_W     = $clog2(MAX_KEY_BYTES);
    localparam int DATA_CNT_W    = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        KEY_WAIT   = 2'd0,   // key not (fully) loaded
        COLLECT    = 2'd1,   // key loaded, staging register accepting data
        STAGE_FULL = 2'd2    // staging holds a full block behind a held output
    } loader_state_t;

endpackage

// File: rtl/aes_byte_accum.sv
// aes_byte_accum: MSB-first byte accumulator with a byte counter.
//   clk, reset : clock, asynchronous active-high reset
//   push       : accept byte_in this cycle
//   byte_in    : byte to store
//   data       : accumulated value; byte k lands at bits [NBYTES*8-1-8k -: 8],
//                bits at and above NBYTES*8 are always 0
//   count      : bytes accepted in the current group (wraps at NBYTES)
//   done       : combinational pulse, high when the last byte of a group is pushed
// The region is cleared when the first byte of a group is pushed.
module aes_byte_accum #(
    parameter int WIDTH  = 128,
    parameter int NBYTES = 16,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] data_nxt;

    always_comb begin
        data_nxt = data;
        if (push) begin
            if (count == '0)
                data_nxt = '0;
            // constant-indexed slices keep the write pattern a plain byte-enable decode
            for (int i = 0; i < NBYTES; i++)
                if (count == CNT_W'(i))
                    data_nxt[(NBYTES-1-i)*8 +: 8] = byte_in;
        end
    end

    assign done = push && (count == CNT_W'(NBYTES-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (push) begin
            data  <= data_nxt;
            count <= done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// aes_stream_loader: assembles key and plaintext bytes from an 8-bit valid/ready
// stream and presents a stable key and 128-bit block to a combinational AES core.
//   clk, reset  : clock, asynchronous active-high reset
//   byte_in     : stream byte; is_key selects key (1) or plaintext (0)
//   byte_valid  : stream valid; byte_ready: loader accepts the byte this cycle
//   key_out     : assembled key in the low NK*32 bits, upper bits 0
//   key_loaded  : all NK*4 key bytes received
//   block_out   : assembled block; block_valid / block_ready: output handshake
//   blk_count   : block handshake counter (only with AES_LOADER_BLKCNT_EN)
// The data accumulator doubles as the staging buffer: a completed block waits
// there while the output is held, so the next block overwrites it only after it
// has moved to block_out.
module aes_stream_loader #(
    parameter int NK = 4,
    parameter int NB = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_in,
    input  logic         is_key,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic [255:0] key_out,
    output logic         key_loaded,
    output logic [127:0] block_out,
    output logic         block_valid,
    input  logic         block_ready
`ifdef AES_LOADER_BLKCNT_EN
   ,output logic [31:0]  blk_count
`endif
);
    import aes_loader_pkg::*;

    if (NB != 4) begin : g_nb_check
        $error("aes_stream_loader: NB must be 4");
    end
    if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
        $error("aes_stream_loader: NK must be 4, 6 or 8");
    end

    loader_state_t           state;
    logic [KEY_CNT_W-1:0]    key_cnt;
    logic [DATA_CNT_W-1:0]   data_cnt;
    logic [127:0]            stage_q;
    logic                    key_done, data_done;
    logic                    key_rdy, data_rdy, key_push, data_push, key_start;
    logic                    stage_full, drain;

    assign stage_full = (state == STAGE_FULL);
    assign key_loaded = (state != KEY_WAIT);
    assign drain      = block_valid && block_ready;

    // Key may only change when nothing derived from the current key is pending.
    assign key_rdy    = (data_cnt == '0) && !stage_full && !block_valid;
    assign data_rdy   = key_loaded && !stage_full;
    assign byte_ready = is_key ? key_rdy : data_rdy;
    assign key_push   = byte_valid && is_key && key_rdy;
    assign data_push  = byte_valid && !is_key && data_rdy;
    assign key_start  = key_push && (key_cnt == '0);

    aes_byte_accum #(.WIDTH(256), .NBYTES(NK*4), .CNT_W(KEY_CNT_W)) u_key_accum (
        .clk     (clk),
        .reset   (reset),
        .push    (key_push),
        .byte_in (byte_in),
        .data    (key_out),
        .count   (key_cnt),
        .done    (key_done)
    );

    aes_byte_accum #(.WIDTH(128), .NBYTES(BLOCK_BYTES), .CNT_W(DATA_CNT_W)) u_data_accum (
        .clk     (clk),
        .reset   (reset),
        .push    (data_push),
        .byte_in (byte_in),
        .data    (stage_q),
        .count   (data_cnt),
        .done    (data_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= KEY_WAIT;
            block_out   <= '0;
            block_valid <= 1'b0;
        end else begin
            if (key_done)
                state <= COLLECT;
            else if (key_start)
                state <= KEY_WAIT;

            if (data_done && (!block_valid || drain)) begin
                // last byte bypasses the staging register straight to the output
                block_out   <= {stage_q[127:8], byte_in};
                block_valid <= 1'b1;
            end else if (data_done) begin
                state <= STAGE_FULL;
            end else if (stage_full && drain) begin
                block_out <= stage_q;       // block_valid stays high: no bubble
                state     <= COLLECT;
            end else if (drain) begin
                block_valid <= 1'b0;
            end
        end
    end

`ifdef AES_LOADER_BLKCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blk_count <= '0;
        else if (key_start)
            blk_count <= '0;
        else if (drain)
            blk_count <= blk_count + 32'd1;
    end
`endif

endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
- Byte-stream front end that sits directly upstream of the combinational AES encrypt core.
- Assembles key bytes and plaintext bytes from an 8-bit valid/ready stream.
- Presents a stable 256-bit key and a 128-bit block to the core under a valid/ready handshake.
- Double-buffers data so the next block can be collected while the current one waits for consumption.

Parameters:
- NK, 4, key length in 32-bit words (legal values 4, 6, 8); key byte count is NK*4.
- NB, 4, block width in 32-bit words; fixed at 4, and any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- byte_in  input  8  stream byte.
- is_key  input  1  qualifies byte_in: 1 = key byte, 0 = plaintext byte.
- byte_valid  input  1  byte_in/is_key valid.
- byte_ready  output  1  loader accepts the byte this cycle.
- key_out  output  256  assembled key, driven to the core key input.
- key_loaded  output  1  all NK*4 key bytes received.
- block_out  output  128  assembled plaintext block, driven to the core data input.
- block_valid  output  1  block_out holds a complete block.
- block_ready  input  1  downstream consumes block_out.

Behaviour:
- Reset: all outputs go to 0, key and data counters to 0, staging empty, key_loaded=0.
- A byte is accepted when byte_valid && byte_ready.
- byte_ready is combinational from is_key and internal state.
- Key bytes:
  - ready iff data count==0, staging empty, and block_valid==0, so the key never changes under a pending block.
  - Key bytes fill MSB-first into the low NK*32 bits: the first byte lands at key_out[NK*32-1 -: 8].
  - Bits above NK*32 are held at 0.
  - Accepting key byte 0 clears key_loaded and clears the key region.
  - Accepting byte NK*4-1 sets key_loaded on the next edge and wraps the key count to 0.
- Data bytes:
  - ready iff key_loaded==1 and staging is not full.
  - Fill the staging register MSB-first: byte 0 goes to bits [127:120].
  - The data count wraps 15 -> 0.
- Staging -> output transfer, triggered when the 16th byte is accepted:
  - If the output is empty, or drains (block_valid && block_ready) in the same cycle, the block moves to block_out and block_valid=1 on the next edge. Latency is 1 cycle from acceptance of the last byte.
  - Otherwise staging is marked full and byte_ready for data drops to 0.
  - Staging moves to the output on the cycle the output drains. block_valid then stays 1 without a gap, and staging empties.
- block_out and key_out are stable while block_valid=1.
- block_valid falls only on handshake with no staged block.
- key_loaded with data count 0 and is_key toggling is legal and starts a rekey only under the key-ready condition above.
- Mid-operation reset (asynchronous) discards partial key and data immediately. block_valid drops in the same cycle reset asserts.
- byte_valid=0 has no effect. is_key is ignored when byte_valid=0.
- FSM state enum: KEY_WAIT (key_loaded=0), COLLECT, STAGE_FULL.
  - KEY_WAIT -> COLLECT on the last key byte.
  - COLLECT -> STAGE_FULL on the 16th data byte while output is held.
  - STAGE_FULL -> COLLECT on output drain.
  - COLLECT -> KEY_WAIT on key byte 0.

Optional Feature:
- Macro AES_LOADER_BLKCNT_EN.
- Defined:
  - Adds output port blk_count[31:0].
  - Increments on each block_valid && block_ready handshake and wraps at 2^32.
  - Reset to 0 by reset and on acceptance of key byte 0.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Package aes_loader_pkg holds:
  - BLOCK_BYTES=16 and MAX_KEY_BYTES=32.
  - Count widths.
  - The state enum type (KEY_WAIT, COLLECT, STAGE_FULL).
- One sub-module, aes_byte_accum: a parameterised MSB-first byte shift accumulator with count and a done pulse. It is instantiated once for the key (width 256, NK*4 bytes) and once for data (width 128, 16 bytes).

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f (NK=4), then plaintext 00112233445566778899aabbccddeeff, block_ready=1 -> key_loaded high after the 16th key byte; block_valid one cycle after the last data byte; block_out=00112233445566778899aabbccddeeff; core output 69c4e0d86a7b0430d8cdb78070b4c55a.
- NK=8, key bytes 00..1f -> key_out=000102...1f across all 256 bits; FIPS-197 plaintext yields core output 8ea2b7ca516745bfeafc49904b496089.
- block_ready=0, stream 48 data bytes -> after byte 32, byte_ready=0 for data. Raising block_ready gives back-to-back block_valid with the second block and no gap, then staging accepts again.
- Data bytes before any key -> byte_ready=0; no block_valid. Key byte offered while data count=5 -> byte_ready=0.
- Assert reset after 9 data bytes -> all outputs 0 within the same cycle. After release, a fresh key and 16 bytes give the correct block.
- With AES_LOADER_BLKCNT_EN: 3 handshakes -> blk_count=3; starting a rekey -> blk_count=0.
